vc_ts_arbiter: RTL and testbench
================================

VC_TS_ARBITER -- requirements
Module: vc_ts_arbiter

Interface
REQ-001 SHALL have parameters: VCS, default 4, number of virtual channels; TS, default 8, time-slots per frame; MAX_TS, default 5, per-VC reservation bound (at most MAX_TS-1 slots); BUF_DEPTH, default 4, downstream VC buffer depth in flits.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_i  in  VCS  VC v holds a flit for this output port.
REQ-006 credit_i  in  VCS  one credit returned by downstream for VC v.
REQ-007 cfg_we_i  in  1  reservation-table write strobe.
REQ-008 cfg_slot_i  in  clog2(TS)  slot index written.
REQ-009 cfg_vc_i  in  clog2(VCS)  owning VC written.
REQ-010 cfg_valid_i  in  1  1 = reserve slot, 0 = release slot.
REQ-011 grant_o  out  VCS  registered one-hot grant; at most one bit set.
REQ-012 grant_gs_o  out  1  registered; current grant came from a reserved slot.
REQ-013 ts_o  out  clog2(TS)  current slot number.
REQ-014 credit_avail_o  out  VCS  credit counter of VC v nonzero.
REQ-015 cfg_err_o  out  1  one-cycle pulse, config write rejected.
REQ-016 credit_err_o  out  1  sticky, credit returned to a full counter.

Function
REQ-017 Slot counter SHALL increment every cycle and wrap TS-1 -> 0.
REQ-018 Reservation table SHALL hold TS entries {valid, vc}, plus per-VC reserved-slot count rcnt[v].
REQ-019 Eligible[v] SHALL be req_i[v] AND credit[v] > 0, evaluated in the cycle before the grant edge.
REQ-020 If table[ts].valid and Eligible[table[ts].vc]: SHALL register grant to that VC with grant_gs_o=1; RR pointer unchanged.
REQ-021 Otherwise: SHALL grant first Eligible VC scanning from rr_ptr upward with wrap (slot reclaimed, work-conserving), grant_gs_o=0, rr_ptr <= granted+1 mod VCS.
REQ-022 No Eligible VC: grant_o=0, grant_gs_o=0, rr_ptr unchanged.
REQ-023 Grant latency SHALL be exactly 1 cycle from req_i sample; grant held one cycle only, one flit per grant.
REQ-024 Credit counters (width clog2(BUF_DEPTH+1)) SHALL decrement on the edge registering a grant to v, increment on credit_i[v]; both together -> unchanged.
REQ-025 credit_i[v] with counter at BUF_DEPTH and no same-cycle grant SHALL leave the counter at BUF_DEPTH and set credit_err_o.
REQ-026 Reserve write SHALL be accepted iff table[slot] already owned by cfg_vc_i, or rcnt[cfg_vc_i] < MAX_TS-1; on accept the old owner's rcnt decrements and the new owner's increments.
REQ-027 Rejected reserve write SHALL leave table and counts unchanged and pulse cfg_err_o the next cycle.
REQ-028 Release write SHALL always be accepted; releasing an invalid slot is a no-op.
REQ-029 Config write SHALL take effect from the cycle after cfg_we_i, including a write to the current slot.
REQ-030 Configuration and arbitration SHALL proceed concurrently without stalling.

Reset
REQ-031 On rst_n low, asynchronously: ts=0, rr_ptr=0, all table entries invalid, rcnt=0, credits=BUF_DEPTH, grant_o=0, grant_gs_o=0, cfg_err_o=0, credit_err_o=0, credit_avail_o all ones.
REQ-032 Reset mid-operation SHALL drop any grant and configuration immediately; first grant possible on the second rising edge after deassertion.

Verification
REQ-033 All req_i=4'b1111, no reservations, credits returned each cycle -> grants cycle VC0,1,2,3,0..., grant_gs_o=0.
REQ-034 Reserve slot 3 for VC2, req_i=4'b1111 -> at ts=3 grant_o=4'b0100 with grant_gs_o=1; rr_ptr not advanced.
REQ-035 Slot 3 reserved for VC2, req_i=4'b0001 -> at ts=3 VC0 granted, grant_gs_o=0.
REQ-036 req_i[1] held, no credit_i -> exactly 4 grants to VC1, then credit_avail_o[1]=0 and no grant; one credit_i[1] -> one further grant.
REQ-037 With MAX_TS=5, reserve slots 0-3 for VC0, then slot 4 for VC0 -> fifth write rejected, cfg_err_o pulses once; rewrite of slot 2 for VC0 accepted.
REQ-038 credit_i[0] pulsed at reset state -> credit counter stays 4, credit_err_o=1 until reset.

Source files
------------

// File: rtl/vc_ts_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vc_ts_arbiter
// Brief    : Output-port virtual-channel arbiter mixing a time-slot
//            reservation table (guaranteed service) with a work-conserving
//            round-robin fallback, gated by per-VC credit counters.
// Revision : 1.0 - initial release
// ============================================================================
//
// Timing summary
//   - The arbitration decision is made combinationally from req_i, the credit
//     counters, the reservation entry of the current slot (ts_o) and rr_ptr,
//     and is registered on the next rising edge. The registered grant is
//     therefore visible while ts_o already shows the following slot.
//   - Configuration writes land on the same edge, so the new table contents
//     steer arbitration from the following cycle onward.
//   - An "armed" flop blocks the very first edge after reset release, so the
//     earliest grant is registered on the second rising edge.

module vc_ts_arbiter #(
  parameter int VCS       = 4,
  parameter int TS        = 8,
  parameter int MAX_TS    = 5,
  parameter int BUF_DEPTH = 4,
  localparam int TW       = (TS  > 1) ? $clog2(TS)  : 1,
  localparam int VW       = (VCS > 1) ? $clog2(VCS) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [VCS-1:0] req_i,
  input  logic [VCS-1:0] credit_i,
  input  logic           cfg_we_i,
  input  logic [TW-1:0]  cfg_slot_i,
  input  logic [VW-1:0]  cfg_vc_i,
  input  logic           cfg_valid_i,
  output logic [VCS-1:0] grant_o,
  output logic           grant_gs_o,
  output logic [TW-1:0]  ts_o,
  output logic [VCS-1:0] credit_avail_o,
  output logic           cfg_err_o,
  output logic           credit_err_o
);

  // --------------------------------------------------------------------------
  // Derived widths and constants
  // --------------------------------------------------------------------------
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int RW = (MAX_TS > 1) ? $clog2(MAX_TS) : 1;

  localparam logic [CW-1:0] CREDIT_FULL = CW'(BUF_DEPTH);
  localparam logic [RW-1:0] RES_LIMIT   = RW'(MAX_TS - 1);
  localparam logic [TW-1:0] TS_LAST     = TW'(TS - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [TW-1:0]  ts;
  logic [VW-1:0]  rr_ptr;
  logic           armed;
  logic [VCS-1:0] grant_q;
  logic           grant_gs_q;
  logic           cfg_err_q;
  logic           credit_err_q;

  // Reservation table: one {valid, vc} entry per slot, plus the number of
  // slots each VC currently owns.
  logic [TS-1:0]  tbl_valid;
  logic [VW-1:0]  tbl_vc [TS];
  logic [RW-1:0]  rcnt   [VCS];

  // --------------------------------------------------------------------------
  // Combinational arbitration signals
  // --------------------------------------------------------------------------
  logic [VCS-1:0] eligible;
  logic [VCS-1:0] overflow;
  logic           slot_valid;
  logic [VW-1:0]  slot_vc;
  logic           slot_hit;
  logic           rr_found;
  logic [VW-1:0]  rr_sel;
  logic           grant_any;
  logic           grant_from_slot;
  logic [VW-1:0]  grant_vc;
  logic [VCS-1:0] grant_next;

  // Modular VC index arithmetic; VCS need not be a power of two.
  function automatic logic [VW-1:0] wrap_vc(input logic [VW-1:0] base,
                                            input int unsigned   offset);
    int unsigned sum;
    sum = 32'(base) + offset;
    if (sum >= unsigned'(VCS)) begin
      sum = sum - unsigned'(VCS);
    end
    return sum[VW-1:0];
  endfunction

  // --------------------------------------------------------------------------
  // Per-VC credit counters and eligibility
  // --------------------------------------------------------------------------
  generate
    for (genvar v = 0; v < VCS; v++) begin : g_credit
      logic [CW-1:0] cnt;
      logic          take;
      logic          give;

      assign take              = grant_next[v];
      assign give              = credit_i[v];
      assign eligible[v]       = armed & req_i[v] & (cnt != '0);
      assign credit_avail_o[v] = (cnt != '0);
      // A credit arriving at a full counter with no consuming grant is lost.
      assign overflow[v]       = give & ~take & (cnt == CREDIT_FULL);

      // Consume one credit per granted flit, recover one per returned credit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= CREDIT_FULL;
        end else if (take && !give) begin
          cnt <= cnt - CW'(1);
        end else if (give && !take && (cnt != CREDIT_FULL)) begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Reserved-slot lookup for the current slot
  // --------------------------------------------------------------------------
  assign slot_valid = tbl_valid[ts];
  assign slot_vc    = tbl_vc[ts];
  assign slot_hit   = slot_valid & eligible[slot_vc];

  // Round-robin search: first eligible VC at or after rr_ptr, with wrap.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    for (int i = 0; i < VCS; i++) begin
      if (!rr_found && eligible[wrap_vc(rr_ptr, i)]) begin
        rr_found = 1'b1;
        rr_sel   = wrap_vc(rr_ptr, i);
      end
    end
  end

  // Reserved slot wins when its owner can send; otherwise the slot is reclaimed.
  always_comb begin
    grant_any       = 1'b0;
    grant_from_slot = 1'b0;
    grant_vc        = '0;
    if (slot_hit) begin
      grant_any       = 1'b1;
      grant_from_slot = 1'b1;
      grant_vc        = slot_vc;
    end else if (rr_found) begin
      grant_any = 1'b1;
      grant_vc  = rr_sel;
    end
  end

  // One-hot expansion of the selected VC.
  always_comb begin
    grant_next = '0;
    if (grant_any) begin
      grant_next[grant_vc] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Slot counter, round-robin pointer and registered grant
  // --------------------------------------------------------------------------
  // The pointer only moves on round-robin grants so reserved service does not
  // disturb best-effort fairness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts         <= '0;
      rr_ptr     <= '0;
      armed      <= 1'b0;
      grant_q    <= '0;
      grant_gs_q <= 1'b0;
    end else begin
      ts         <= (ts == TS_LAST) ? '0 : ts + TW'(1);
      armed      <= 1'b1;
      grant_q    <= grant_next;
      grant_gs_q <= grant_from_slot;
      if (grant_any && !grant_from_slot) begin
        rr_ptr <= wrap_vc(rr_sel, 1);
      end
    end
  end

  // Credit overflow is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_err_q <= 1'b0;
    end else if (|overflow) begin
      credit_err_q <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Configuration path
  // --------------------------------------------------------------------------
  logic          slot_ok;
  logic          vc_ok;
  logic          old_valid;
  logic [VW-1:0] old_vc;
  logic          owned;
  logic          res_accept;

  // Index range guards are only needed when the index fields are wider than
  // the table / VC count; for power-of-two sizes every code is legal.
  generate
    if ((1 << TW) == TS) begin : g_slot_pow2
      assign slot_ok = 1'b1;
    end else begin : g_slot_range
      assign slot_ok = (32'(cfg_slot_i) < unsigned'(TS));
    end
    if ((1 << VW) == VCS) begin : g_vc_pow2
      assign vc_ok = 1'b1;
    end else begin : g_vc_range
      assign vc_ok = (32'(cfg_vc_i) < unsigned'(VCS));
    end
  endgenerate

  assign old_valid  = tbl_valid[cfg_slot_i];
  assign old_vc     = tbl_vc[cfg_slot_i];
  assign owned      = old_valid & (old_vc == cfg_vc_i);
  // Re-reserving a slot the VC already owns never grows its count.
  assign res_accept = vc_ok & (owned | (rcnt[cfg_vc_i] < RES_LIMIT));

  // Apply reserve/release writes and keep per-VC ownership counts in step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_valid <= '0;
      for (int s = 0; s < TS; s++) begin
        tbl_vc[s] <= '0;
      end
      for (int v = 0; v < VCS; v++) begin
        rcnt[v] <= '0;
      end
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      if (cfg_we_i && slot_ok) begin
        if (cfg_valid_i) begin
          if (res_accept) begin
            tbl_valid[cfg_slot_i] <= 1'b1;
            tbl_vc[cfg_slot_i]    <= cfg_vc_i;
            if (!owned) begin
              // Ownership moves: previous owner (if any) loses a slot.
              if (old_valid) begin
                rcnt[old_vc] <= rcnt[old_vc] - RW'(1);
              end
              rcnt[cfg_vc_i] <= rcnt[cfg_vc_i] + RW'(1);
            end
          end else begin
            cfg_err_q <= 1'b1;
          end
        end else if (old_valid) begin
          tbl_valid[cfg_slot_i] <= 1'b0;
          rcnt[old_vc]          <= rcnt[old_vc] - RW'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign grant_o      = grant_q;
  assign grant_gs_o   = grant_gs_q;
  assign ts_o         = ts;
  assign cfg_err_o    = cfg_err_q;
  assign credit_err_o = credit_err_q;

endmodule

`default_nettype wire

// File: tb/tb_vc_ts_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vc_ts_arbiter
// Brief    : Scoreboard bench for vc_ts_arbiter. Stimulus is driven on the
//            falling edge and a reference model pushes the expected post-edge
//            outputs; a monitor pops and compares one entry per rising edge.
// Revision : 1.0 - initial release
// ============================================================================

module tb_vc_ts_arbiter;

  localparam int VCS       = 4;
  localparam int TS        = 8;
  localparam int MAX_TS    = 5;
  localparam int BUF_DEPTH = 4;
  localparam int TW        = $clog2(TS);
  localparam int VW        = $clog2(VCS);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [VCS-1:0] req_i = '0;
  logic [VCS-1:0] credit_i = '0;
  logic           cfg_we_i = 1'b0;
  logic [TW-1:0]  cfg_slot_i = '0;
  logic [VW-1:0]  cfg_vc_i = '0;
  logic           cfg_valid_i = 1'b0;
  logic [VCS-1:0] grant_o;
  logic           grant_gs_o;
  logic [TW-1:0]  ts_o;
  logic [VCS-1:0] credit_avail_o;
  logic           cfg_err_o;
  logic           credit_err_o;

  vc_ts_arbiter #(
    .VCS(VCS), .TS(TS), .MAX_TS(MAX_TS), .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .credit_i(credit_i),
    .cfg_we_i(cfg_we_i), .cfg_slot_i(cfg_slot_i), .cfg_vc_i(cfg_vc_i),
    .cfg_valid_i(cfg_valid_i), .grant_o(grant_o), .grant_gs_o(grant_gs_o),
    .ts_o(ts_o), .credit_avail_o(credit_avail_o), .cfg_err_o(cfg_err_o),
    .credit_err_o(credit_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VCS-1:0] grant;
    logic           gs;
    logic [TW-1:0]  ts;
    logic [VCS-1:0] cavail;
    logic           cfg_err;
    logic           cred_err;
  } exp_t;

  typedef struct {
    logic [VCS-1:0] grant;
    logic           gs;
    logic [TW-1:0]  ts;
    logic           cfg_err;
  } obs_t;

  exp_t sb[$];
  obs_t log_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;

  // Reference model state: plain integers and arrays.
  int             m_credit [VCS];
  bit             m_tv     [TS];
  int             m_tvc    [TS];
  int             m_ts;
  int             m_rr;
  bit             m_armed;
  bit             m_cred_err;
  logic [VCS-1:0] m_last_grant;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int v = 0; v < VCS; v++) m_credit[v] = BUF_DEPTH;
    for (int s = 0; s < TS; s++) begin
      m_tv[s]  = 1'b0;
      m_tvc[s] = 0;
    end
    m_ts = 0; m_rr = 0; m_armed = 1'b0; m_cred_err = 1'b0; m_last_grant = '0;
  endfunction

  // One clock of stimulus: drive inputs, predict the post-edge outputs.
  task automatic step(input logic [VCS-1:0] req, input logic [VCS-1:0] cr,
                      input bit we, input int slot, input int vc, input bit valid);
    int   gvc;
    bit   gs;
    int   cnt;
    bit   owned;
    bit   elig [VCS];
    exp_t e;
    @(negedge clk);
    req_i = req; credit_i = cr; cfg_we_i = we;
    cfg_slot_i = TW'(slot); cfg_vc_i = VW'(vc); cfg_valid_i = valid;

    gvc = -1; gs = 1'b0;
    for (int v = 0; v < VCS; v++) elig[v] = m_armed && req[v] && (m_credit[v] > 0);
    if (m_tv[m_ts] && elig[m_tvc[m_ts]]) begin
      gvc = m_tvc[m_ts];
      gs  = 1'b1;
    end else begin
      for (int i = 0; i < VCS; i++) begin
        if (gvc < 0 && elig[(m_rr + i) % VCS]) gvc = (m_rr + i) % VCS;
      end
      if (gvc >= 0) m_rr = (gvc + 1) % VCS;
    end

    for (int v = 0; v < VCS; v++) begin
      if (gvc == v && !cr[v]) m_credit[v]--;
      else if (cr[v] && gvc != v) begin
        if (m_credit[v] == BUF_DEPTH) m_cred_err = 1'b1;
        else m_credit[v]++;
      end
    end

    e.cfg_err = 1'b0;
    if (we) begin
      if (valid) begin
        cnt = 0;
        for (int s = 0; s < TS; s++) if (m_tv[s] && m_tvc[s] == vc) cnt++;
        owned = m_tv[slot] && (m_tvc[slot] == vc);
        if (owned || cnt < MAX_TS - 1) begin
          m_tv[slot]  = 1'b1;
          m_tvc[slot] = vc;
        end else e.cfg_err = 1'b1;
      end else m_tv[slot] = 1'b0;
    end

    m_ts    = (m_ts + 1) % TS;
    m_armed = 1'b1;
    e.grant = '0;
    if (gvc >= 0) e.grant[gvc] = 1'b1;
    e.gs = gs;
    e.ts = TW'(m_ts);
    for (int v = 0; v < VCS; v++) e.cavail[v] = (m_credit[v] > 0);
    e.cred_err = m_cred_err;
    m_last_grant = e.grant;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    req_i = '0; credit_i = '0; cfg_we_i = 1'b0; cfg_valid_i = 1'b0;
    cfg_slot_i = '0; cfg_vc_i = '0;
  endtask

  // Asynchronous reset away from any edge, with immediate output checks.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("rst_grant",        32'(grant_o),        32'd0);
    check("rst_grant_gs",     32'(grant_gs_o),     32'd0);
    check("rst_ts",           32'(ts_o),           32'd0);
    check("rst_credit_avail", 32'(credit_avail_o), 32'hF);
    check("rst_cfg_err",      32'(cfg_err_o),      32'd0);
    check("rst_credit_err",   32'(credit_err_o),   32'd0);
    model_reset();
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected entry per rising edge after each pushed step.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("grant",        32'(grant_o),        32'(mon_e.grant));
        check("grant_gs",     32'(grant_gs_o),     32'(mon_e.gs));
        check("ts",           32'(ts_o),           32'(mon_e.ts));
        check("credit_avail", 32'(credit_avail_o), 32'(mon_e.cavail));
        check("cfg_err",      32'(cfg_err_o),      32'(mon_e.cfg_err));
        check("credit_err",   32'(credit_err_o),   32'(mon_e.cred_err));
        log_q.push_back('{grant_o, grant_gs_o, ts_o, cfg_err_o});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n_gs;
    logic [VCS-1:0] g;

    // Credit returned to a full counter right out of reset.
    do_reset();
    step(4'b0000, 4'b0001, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(4'b0000, 4'b0000, 0, 0, 0, 0);
    settle();
    check("credit_err_sticky", 32'(credit_err_o), 32'd1);
    check("credit_full_kept", 32'(credit_avail_o), 32'hF);

    // Plain round robin with all VCs requesting; first edge after reset idle.
    do_reset();
    log_q.delete();
    for (int k = 0; k < 10; k++) step(4'b1111, m_last_grant, 0, 0, 0, 0);
    settle();
    check("first_edge_no_grant", 32'(log_q[0].grant), 32'd0);
    for (int k = 1; k < 9; k++) begin
      check("rr_order", 32'(log_q[k].grant), 32'(1 << ((k - 1) % 4)));
      check("rr_not_gs", 32'(log_q[k].gs), 32'd0);
    end

    // Credit exhaustion on VC1, then a single credit allows a single flit.
    do_reset();
    log_q.delete();
    for (int k = 0; k < 8; k++) step(4'b0010, 4'b0000, 0, 0, 0, 0);
    settle();
    n = 0;
    foreach (log_q[i]) if (log_q[i].grant == 4'b0010) n++;
    check("vc1_grants_exhaust", 32'(n), 32'd4);
    check("vc1_no_credit", 32'(credit_avail_o[1]), 32'd0);
    step(4'b0010, 4'b0010, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(4'b0010, 4'b0000, 0, 0, 0, 0);
    settle();
    n = 0;
    foreach (log_q[i]) if (log_q[i].grant == 4'b0010) n++;
    check("vc1_grants_after_credit", 32'(n), 32'd5);

    // Slot 3 reserved for VC2: guaranteed grant, RR pointer untouched.
    do_reset();
    step(4'b0000, 4'b0000, 1, 3, 2, 1);
    log_q.delete();
    for (int k = 0; k < 24; k++) step(4'b1111, m_last_grant, 0, 0, 0, 0);
    settle();
    n_gs = 0;
    foreach (log_q[i]) begin
      if (log_q[i].gs) begin
        n_gs++;
        check("gs_grant_vc2", 32'(log_q[i].grant), 32'b0100);
        check("gs_after_slot3", 32'(log_q[i].ts), 32'd4);
        if (i > 0 && i + 1 < log_q.size() && log_q[i - 1].grant != '0) begin
          g = log_q[i - 1].grant;
          check("rr_held_over_gs", 32'(log_q[i + 1].grant), 32'({g[2:0], g[3]}));
        end
      end
    end
    check("gs_count", 32'(n_gs >= 2), 32'd1);

    // Reserved slot reclaimed when its owner is not requesting.
    log_q.delete();
    for (int k = 0; k < 16; k++) step(4'b0001, m_last_grant, 0, 0, 0, 0);
    settle();
    foreach (log_q[i]) begin
      if (log_q[i].ts == 3'd4) begin
        check("reclaim_vc0", 32'(log_q[i].grant), 32'b0001);
        check("reclaim_not_gs", 32'(log_q[i].gs), 32'd0);
      end
    end

    // Reservation bound: four slots for VC0 fit, the fifth is refused.
    do_reset();
    log_q.delete();
    for (int s = 0; s < 5; s++) step(4'b0000, 4'b0000, 1, s, 0, 1);
    step(4'b0000, 4'b0000, 1, 2, 0, 1);
    step(4'b0000, 4'b0000, 0, 0, 0, 0);
    step(4'b0000, 4'b0000, 0, 0, 0, 0);
    settle();
    n = 0;
    foreach (log_q[i]) if (log_q[i].cfg_err) n++;
    check("cfg_err_count", 32'(n), 32'd1);
    check("cfg_err_on_fifth", 32'(log_q[4].cfg_err), 32'd1);

    // Randomised traffic with concurrent configuration and a mid-run reset.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if (k == 700) do_reset();
      step(VCS'($urandom),
           ($urandom_range(0, 1) ? m_last_grant : '0) | VCS'($urandom & $urandom & $urandom),
           ($urandom_range(0, 5) == 0), $urandom_range(0, TS - 1),
           $urandom_range(0, VCS - 1), ($urandom_range(0, 3) != 0));
    end
    settle();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
